wb_write_queue: RTL

//  Write side of the 15-entry register file. Buffers write-back requests from the MEM/WB stage
//  in a small in-order FIFO and drains one entry per cycle onto the file's single write port
//  (writeBackEn / dest_wb / result_WB). Lets MEM retire while the write port is held, e.g. by an

---
 rtl/wb_write_queue_pkg.sv | 20 ++
 rtl/wb_write_queue_if.sv | 33 +++
 rtl/wb_write_queue_match.sv | 33 +++
 rtl/wb_write_queue.sv | 99 +++++++++
 4 files changed

// File: rtl/wb_write_queue_pkg.sv
// rtl/wb_write_queue_pkg.sv - shared widths, queue depth and PC register index for the write-back queue
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_FILE_ADDRESS_LEN
`define REG_FILE_ADDRESS_LEN 4
`endif
`ifndef WBQ_DEPTH
`define WBQ_DEPTH 4
`endif
`ifndef PC_REG_IDX
`define PC_REG_IDX 4'hF
`endif

package wb_write_queue_pkg;
    localparam int WBQ_DW    = `WORD_WIDTH;
    localparam int WBQ_AW    = `REG_FILE_ADDRESS_LEN;
    localparam int WBQ_DEPTH = `WBQ_DEPTH;
    localparam logic [WBQ_AW-1:0] PC_REG = `PC_REG_IDX;
endpackage

// File: rtl/wb_write_queue_if.sv
// rtl/wb_write_queue_if.sv - request, register-file write port and hazard query bundle
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 4
) ();
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [AW-1:0]            in_dest;
    logic [DW-1:0]            in_data;
    logic                     wb_hold;
    logic                     wb_en;
    logic [AW-1:0]            wb_dest;
    logic [DW-1:0]            wb_result;
    logic [AW-1:0]            q_src1;
    logic [AW-1:0]            q_src2;
    logic                     hz1;
    logic                     hz2;
    logic [DW-1:0]            fwd1;
    logic [DW-1:0]            fwd2;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, in_valid, in_dest, in_data, wb_hold, q_src1, q_src2,
        input  in_ready, wb_en, wb_dest, wb_result, hz1, hz2, fwd1, fwd2, count
    );

    modport slave (
        input  flush, in_valid, in_dest, in_data, wb_hold, q_src1, q_src2,
        output in_ready, wb_en, wb_dest, wb_result, hz1, hz2, fwd1, fwd2, count
    );
endinterface

// File: rtl/wb_write_queue_match.sv
// rtl/wb_write_queue_match.sv - wbq_match: finds the youngest queued entry targeting a query register
module wbq_match #(
    parameter int               DEPTH  = 4,
    parameter int               DW     = 32,
    parameter int               AW     = 4,
    parameter logic [AW-1:0]    PC_IDX = '1
) (
    input  logic [DEPTH-1:0][AW-1:0]    dest_i,
    input  logic [DEPTH-1:0][DW-1:0]    data_i,
    input  logic [DEPTH-1:0]            valid_i,
    input  logic [$clog2(DEPTH)-1:0]    rd_ptr_i,
    input  logic [AW-1:0]               addr_i,
    output logic                        hit_o,
    output logic [DW-1:0]               data_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk entries oldest to youngest so the last hit wins, i.e. the youngest value is forwarded.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_i + PW'(i);
            if (valid_i[idx] && (dest_i[idx] == addr_i) && (addr_i != PC_IDX)) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end
endmodule

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - in-order write-back FIFO in front of the register file write port
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH,
    parameter int DW    = WBQ_DW,
    parameter int AW    = WBQ_AW
) (
    input  logic                clk,
    input  logic                rst,
    wb_write_queue_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] PC_IDX = AW'(PC_REG);

    logic [DEPTH-1:0][AW-1:0]   dest_q;
    logic [DEPTH-1:0][DW-1:0]   data_q;
    logic [PW-1:0]              rd_ptr_q;
    logic [PW-1:0]              wr_ptr_q;
    logic [CW-1:0]              count_q;
    logic [CW-1:0]              count_d;
    logic [DEPTH-1:0]           valid;
    logic                       push;
    logic                       pop;

    assign bus.in_ready  = (count_q < CW'(DEPTH)) && rst;
    assign bus.wb_en     = (count_q != '0) && !bus.wb_hold && rst;
    assign bus.wb_dest   = dest_q[rd_ptr_q];
    assign bus.wb_result = data_q[rd_ptr_q];
    assign bus.count     = count_q;

    // Requests to the PC index complete the handshake but are never stored.
    assign push = bus.in_valid && bus.in_ready && (bus.in_dest != PC_IDX) && !bus.flush;
    assign pop  = bus.wb_en && !bus.flush;

    // Slot j is occupied when its distance from the head is below the occupancy.
    always_comb begin
        valid = '0;
        for (int j = 0; j < DEPTH; j++) begin
            valid[j] = {1'b0, PW'(j) - rd_ptr_q} < count_q;
        end
    end

    // Occupancy next state; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer, occupancy and storage update; flush empties the queue and beats push/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dest_q   <= '0;
            data_q   <= '0;
        end else if (bus.flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                dest_q[wr_ptr_q] <= bus.in_dest;
                data_q[wr_ptr_q] <= bus.in_data;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    wbq_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .PC_IDX(PC_IDX)) u_match1 (
        .dest_i   (dest_q),
        .data_i   (data_q),
        .valid_i  (valid),
        .rd_ptr_i (rd_ptr_q),
        .addr_i   (bus.q_src1),
        .hit_o    (bus.hz1),
        .data_o   (bus.fwd1)
    );

    wbq_match #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .PC_IDX(PC_IDX)) u_match2 (
        .dest_i   (dest_q),
        .data_i   (data_q),
        .valid_i  (valid),
        .rd_ptr_i (rd_ptr_q),
        .addr_i   (bus.q_src2),
        .hit_o    (bus.hz2),
        .data_o   (bus.fwd2)
    );
endmodule
